// File: rtl/mux_stream_pkg.sv
// mux_stream_pkg
// Shared types and helpers for the mux stream responder.
//   STATE_W  : width of the occupancy state encoding
//   state_t  : occupancy state (EMPTY / PARTIAL / FULL); encoding 3 is illegal
//   mux_sel  : one-bit 2:1 select; callers apply it across their own data
//              width, so the result width follows the caller's DATA_WITH.
package mux_stream_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    function automatic logic mux_sel(input logic a, input logic b, input logic sel);
        return sel ? b : a;
    endfunction

endpackage

// File: rtl/mux_stream_fifo.sv
// mux_stream_fifo
// Synchronous FIFO holding {y, sel} response entries.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/occupancy)
//   push       : write wdata at the write pointer (caller guarantees not full)
//   pop        : advance the read pointer (caller guarantees not empty)
//   wdata      : entry to write
//   rdata      : entry at the read pointer (meaningless when occupancy is 0)
//   occupancy  : number of stored entries, 0..DEPTH
module mux_stream_fifo #(
    parameter int DATA_WIDTH = 13,
    parameter int DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    // DEPTH is a power of two, so the pointers wrap naturally with no gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage needs no reset: stale entries are never visible because the
    // top masks the head when occupancy is zero.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/mux_stream_responder.sv
// mux_stream_responder
// Registered 2:1 select responder: accepts (a, b, sel) requests, computes
// y = sel ? b : a, queues {y, sel} in a response FIFO and returns it.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid is never withdrawn and the payload holds stable until
// the transfer. o_req_ready depends on registered occupancy only, so a pop
// from a full FIFO does not free a slot until the following cycle.
// Ports:
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_req_valid/o_req_ready: request handshake; i_a, i_b, i_sel payload
//   o_rsp_valid/i_rsp_ready: response handshake; o_y, o_rsp_sel payload
//                            (forced to 0 when empty)
//   o_state                : occupancy state 0 EMPTY, 1 PARTIAL, 2 FULL
//   o_txn_count            : completed response handshakes, wraps
module mux_stream_responder
    import mux_stream_pkg::*;
#(
    parameter int DATA_WITH  = 12,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [DATA_WITH-1:0] i_a,
    input  logic [DATA_WITH-1:0] i_b,
    input  logic                 i_sel,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [DATA_WITH-1:0] o_y,
    output logic                 o_rsp_sel,
    output logic [STATE_W-1:0]   o_state,
    output logic [CNT_WIDTH-1:0] o_txn_count
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = DATA_WITH + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] ONE_OCC   = OCC_W'(1);

    logic                 push;
    logic                 pop;
    logic [OCC_W-1:0]     occupancy;
    logic [DATA_WITH-1:0] y_sel;
    logic [ENT_W-1:0]     wdata;
    logic [ENT_W-1:0]     rdata;
    state_t               state;
    state_t               state_next;

    assign push = i_req_valid && o_req_ready;
    assign pop  = o_rsp_valid && i_rsp_ready;

    always_comb begin
        y_sel = '0;
        for (int i = 0; i < DATA_WITH; i++) begin
            y_sel[i] = mux_sel(i_a[i], i_b[i], i_sel);
        end
    end

    assign wdata = {y_sel, i_sel};

    mux_stream_fifo #(
        .DATA_WIDTH(ENT_W),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push     (push),
        .pop      (pop),
        .wdata    (wdata),
        .rdata    (rdata),
        .occupancy(occupancy)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_EMPTY;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (push) state_next = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (push && !pop && occupancy == DEPTH_OCC - 1'b1) state_next = ST_FULL;
                else if (pop && !push && occupancy == ONE_OCC)     state_next = ST_EMPTY;
            end
            ST_FULL: begin
                if (pop) state_next = ST_PARTIAL;
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  o_txn_count <= '0;
        else if (pop)  o_txn_count <= o_txn_count + 1'b1;
    end

    assign o_req_ready = (occupancy != DEPTH_OCC);
    assign o_rsp_valid = (occupancy != '0);
    assign o_y         = o_rsp_valid ? rdata[ENT_W-1:1] : '0;
    assign o_rsp_sel   = o_rsp_valid & rdata[0];
    assign o_state     = state;

endmodule

// File: tb/tb_mux_stream_responder.sv
module tb_mux_stream_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [11:0] a = '0;
  logic [11:0] b = '0;
  logic        sel = 1'b0;
  logic        rsp_ready = 1'b0;

  logic        req_ready, rsp_valid, rsp_sel;
  logic [11:0] y;
  logic [1:0]  state;
  logic [15:0] txn_count;

  logic        req_ready_w, rsp_valid_w, rsp_sel_w;
  logic [11:0] y_w;
  logic [1:0]  state_w;
  logic [3:0]  txn_count_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_stream_responder #(.DATA_WITH(12), .FIFO_DEPTH(2), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_a(a), .i_b(b), .i_sel(sel), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_y(y), .o_rsp_sel(rsp_sel), .o_state(state), .o_txn_count(txn_count)
  );

  // Same stimulus, narrow counter for the wrap boundary.
  mux_stream_responder #(.DATA_WITH(12), .FIFO_DEPTH(2), .CNT_WIDTH(4)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready_w),
    .i_a(a), .i_b(b), .i_sel(sel), .o_rsp_valid(rsp_valid_w), .i_rsp_ready(rsp_ready),
    .o_y(y_w), .o_rsp_sel(rsp_sel_w), .o_state(state_w), .o_txn_count(txn_count_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    step();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || y !== 12'h000 || rsp_sel !== 1'b0
        || state !== 2'd0 || txn_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_values: rdy=%b vld=%b y=%h sel=%b st=%0d cnt=%0d required rdy=1 vld=0 y=000 sel=0 st=0 cnt=0",
               req_ready, rsp_valid, y, rsp_sel, state, txn_count);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    a = 12'hABC; b = 12'h123; sel = 1'b1;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || y !== 12'h123 || rsp_sel !== 1'b1 || state !== 2'd1 || txn_count !== 16'd0) begin
      failures++;
      $display("FAIL single_rsp: vld=%b y=%h sel=%b st=%0d cnt=%0d required 1 123 1 1 0",
               rsp_valid, y, rsp_sel, state, txn_count);
    end
    step();
    checks++;
    if (txn_count !== 16'd1 || rsp_valid !== 1'b0 || y !== 12'h000 || state !== 2'd0) begin
      failures++;
      $display("FAIL single_done: cnt=%0d vld=%b y=%h st=%0d required 1 0 000 0",
               txn_count, rsp_valid, y, state);
    end
  endtask

  task automatic test_back_pressure();
    rsp_ready = 1'b0;
    req_valid = 1'b1; a = 12'h00F; b = 12'h777; sel = 1'b0;
    step();
    a = 12'h333; b = 12'hF00; sel = 1'b1;
    step();
    checks++;
    if (state !== 2'd2 || req_ready !== 1'b0 || y !== 12'h00F || rsp_sel !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: st=%0d rdy=%b y=%h sel=%b required 2 0 00F 0", state, req_ready, y, rsp_sel);
    end
    // Third request must stall while the response side is blocked.
    a = 12'h555; b = 12'h666; sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (state !== 2'd2 || req_ready !== 1'b0 || y !== 12'h00F || rsp_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: st=%0d rdy=%b y=%h vld=%b required 2 0 00F 1",
                 i, state, req_ready, y, rsp_valid);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    checks++;
    if (y !== 12'hF00 || rsp_sel !== 1'b1 || state !== 2'd1) begin
      failures++;
      $display("FAIL bp_second: y=%h sel=%b st=%0d required F00 1 1", y, rsp_sel, state);
    end
    step();
    checks++;
    if (state !== 2'd0 || rsp_valid !== 1'b0 || txn_count !== 16'd3) begin
      failures++;
      $display("FAIL bp_drain: st=%0d vld=%b cnt=%0d required 0 0 3", state, rsp_valid, txn_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_q[$];
    logic [11:0] exp_y;
    rsp_ready = 1'b1;
    sel = 1'b0;
    b = 12'hFFF;
    for (int i = 0; i < 10; i++) begin
      a = 12'h100 + 12'(i);
      req_valid = 1'b1;
      exp_q.push_back(12'h100 + 12'(i));
      step();
      exp_y = exp_q.pop_front();
      checks++;
      if (state !== 2'd1 || req_ready !== 1'b1 || y !== exp_y) begin
        failures++;
        $display("FAIL stream[%0d]: st=%0d rdy=%b y=%h required 1 1 %h", i, state, req_ready, y, exp_y);
      end
    end
    req_valid = 1'b0;
    step();
    checks++;
    if (txn_count !== 16'd13 || state !== 2'd0) begin
      failures++;
      $display("FAIL stream_count: cnt=%0d st=%0d required 13 0", txn_count, state);
    end
  endtask

  task automatic test_full_pop();
    rsp_ready = 1'b0;
    req_valid = 1'b1; sel = 1'b0;
    a = 12'h200; step();
    a = 12'h201; step();
    a = 12'h202;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (state !== 2'd2 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_pre: st=%0d rdy=%b required 2 0", state, req_ready);
    end
    step();
    rsp_ready = 1'b0;
    checks++;
    if (state !== 2'd1 || y !== 12'h201 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_nopush: st=%0d y=%h rdy=%b required 1 201 1", state, y, req_ready);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (state !== 2'd2 || y !== 12'h201) begin
      failures++;
      $display("FAIL full_pop_refill: st=%0d y=%h required 2 201", state, y);
    end
    rsp_ready = 1'b1;
    step();
    checks++;
    if (y !== 12'h202 || state !== 2'd1) begin
      failures++;
      $display("FAIL full_pop_order: y=%h st=%0d required 202 1", y, state);
    end
    step();
    checks++;
    if (txn_count !== 16'd16 || txn_count_w !== 4'd0 || state !== 2'd0) begin
      failures++;
      $display("FAIL full_pop_count: cnt=%0d cnt4=%0d st=%0d required 16 0 0", txn_count, txn_count_w, state);
    end
  endtask

  task automatic test_wrap();
    a = 12'h0AA; b = 12'h0BB; sel = 1'b0;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (txn_count_w !== 4'd1 || txn_count !== 16'd17) begin
      failures++;
      $display("FAIL wrap: cnt4=%0d cnt=%0d required 1 17", txn_count_w, txn_count);
    end
  endtask

  task automatic test_reset_midstream();
    rsp_ready = 1'b0;
    req_valid = 1'b1; sel = 1'b1; b = 12'h444;
    step();
    b = 12'h888;
    step();
    req_valid = 1'b0;
    checks++;
    if (state !== 2'd2 || rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_pre: st=%0d vld=%b required 2 1", state, rsp_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || y !== 12'h000 || rsp_sel !== 1'b0
        || state !== 2'd0 || txn_count !== 16'd0 || txn_count_w !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset_async: rdy=%b vld=%b y=%h sel=%b st=%0d cnt=%0d cnt4=%0d required 1 0 000 0 0 0 0",
               req_ready, rsp_valid, y, rsp_sel, state, txn_count, txn_count_w);
    end
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || state !== 2'd0 || req_ready !== 1'b1 || txn_count !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset_after: vld=%b st=%0d rdy=%b cnt=%0d required 0 0 1 0",
               rsp_valid, state, req_ready, txn_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_pressure();
    test_back_to_back();
    test_full_pop();
    test_wrap();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
